// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between the in-order pipeline
//   writeback (MEM/WB outputs) and results coming back from a multi-cycle
//   long-latency unit (divider / multiplier). Long-unit results wait in a
//   small FIFO. The FIFO drains whenever the pipeline has no real write that
//   cycle. If the FIFO head is starved for too long, a one-cycle pipeline
//   stall is forced so the head can retire.
//
// Parameters:
//   DEPTH     long-unit result FIFO entries (power of two, >= 2)
//   MAX_WAIT  cycles the FIFO head may be denied before a forced grant (>= 1)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   pipe_we     in   pipeline writeback enable
//   pipe_rd     in   pipeline destination register [4:0]
//   pipe_data   in   pipeline writeback data [31:0]
//   lu_valid    in   long-unit result valid
//   lu_rd       in   long-unit destination register [4:0]
//   lu_data     in   long-unit result data [31:0]
//   lu_ready    out  FIFO can accept a long-unit result
//   rf_we       out  register-file write enable
//   rf_waddr    out  register-file write address [4:0]
//   rf_wdata    out  register-file write data [31:0]
//   stall_pipe  out  freeze the pipeline this cycle (forced FIFO retire)
//   lu_pending  out  FIFO holds at least one result
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_pipe,
  output logic        lu_pending
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [4:0]    r_memRd   [DEPTH];
  logic [31:0]   r_memData [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_waitCnt;

  logic        w_pipeEff;
  logic        w_headValid;
  logic        w_luReady;
  logic        w_push;
  logic        w_pop;
  logic        w_grantPipe;
  logic        w_stall;
  logic [4:0]  w_headRd;
  logic [31:0] w_headData;

  // A write to x0 is architecturally a no-op, so it never claims the port
  // and never occupies a FIFO slot.
  assign w_pipeEff   = pipe_we && (pipe_rd != 5'd0);
  assign w_headValid = (r_count != '0);
  assign w_headRd    = r_memRd[r_rdPtr];
  assign w_headData  = r_memData[r_rdPtr];

  // Ready comes only from the registered count; a pop in the same cycle as
  // a full FIFO does not open a slot until the following cycle.
  assign w_luReady = (r_count != FULL_COUNT) && !rst;
  assign w_push    = lu_valid && w_luReady && (lu_rd != 5'd0);

  // Next-state and grant decision. In NORMAL the pipeline always wins; the
  // FIFO only gets bubbles. The FORCE state is entered on the edge where
  // the head has been denied for MAX_WAIT cycles, and in that state the
  // pipeline is frozen so the head takes the port.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_grantPipe = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      NORMAL: begin
        if (w_pipeEff) begin
          w_grantPipe = 1'b1;
        end else if (w_headValid) begin
          w_pop = 1'b1;
        end
        if (w_headValid && !w_pop && (r_waitCnt == WAIT_LAST)) begin
          w_nextState = FORCE;
        end
      end
      FORCE: begin
        w_stall     = 1'b1;
        w_pop       = w_headValid;
        w_nextState = NORMAL;
      end
      default: begin
        w_nextState = NORMAL;
      end
    endcase
  end

  // Output mux. Everything is held at zero while reset is asserted so the
  // register file sees no spurious write during reset.
  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    stall_pipe = 1'b0;
    lu_ready   = 1'b0;
    lu_pending = 1'b0;
    if (!rst) begin
      lu_ready   = w_luReady;
      lu_pending = w_headValid;
      stall_pipe = w_stall;
      if (w_grantPipe) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end else if (w_pop) begin
        rf_we    = 1'b1;
        rf_waddr = w_headRd;
        rf_wdata = w_headData;
      end
    end
  end

  // FIFO storage. Contents need no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memRd[r_wrPtr]   <= lu_rd;
      r_memData[r_wrPtr] <= lu_data;
    end
  end

  // State, pointers, occupancy and starvation timer. Pointers wrap
  // naturally because DEPTH is a power of two. The starvation timer only
  // runs while a head exists and is being denied, and restarts on every pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= NORMAL;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_waitCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop || !w_headValid) begin
        r_waitCnt <= '0;
      end else if (r_waitCnt != WAIT_SAT) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
    end
  end

endmodule
